// File: rtl/mod_add_pipe_if.sv
// mod_add_pipe_if: operand/result handshake bundle for the pipelined add/sub/slt unit
interface mod_add_pipe_if #(parameter int WIDTH = 32);
  logic             in_valid, in_ready, out_valid, out_ready, carry, overflow, zero;
  logic [1:0]       op;
  logic [WIDTH-1:0] a, b, result;
  modport master (output in_valid, op, a, b, out_ready,
                  input  in_ready, out_valid, result, carry, overflow, zero);
  modport slave  (input  in_valid, op, a, b, out_ready,
                  output in_ready, out_valid, result, carry, overflow, zero);
endinterface

// File: rtl/mod_add_pipe.sv
// mod_add_pipe: add/sub/slt/sltu with the carry rippling one CW-bit chunk per pipeline stage
module mod_add_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic          clk,
  input logic          rst_n,
  mod_add_pipe_if.slave bus
);
  localparam int CW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;
  logic             vR [STAGES], cR [STAGES], inV [STAGES], inC [STAGES], nC [STAGES];
  logic [1:0]       opR [STAGES], inOp [STAGES];
  logic [WIDTH-1:0] aR [STAGES], bR [STAGES], sR [STAGES];
  logic [WIDTH-1:0] inA [STAGES], inB [STAGES], inS [STAGES], nS [STAGES];
  logic [CW:0]      t;
  logic             adv, sgnN, sgnV;
  assign adv = bus.out_ready || !bus.out_valid;
  always_comb begin
    inA[0]  = bus.a;
    inB[0]  = bus.op == 2'b00 ? bus.b : ~bus.b;
    inS[0]  = '0;
    inC[0]  = bus.op != 2'b00;
    inOp[0] = bus.op;
    inV[0]  = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      inA[k]  = aR[k-1];
      inB[k]  = bR[k-1];
      inS[k]  = sR[k-1];
      inC[k]  = cR[k-1];
      inOp[k] = opR[k-1];
      inV[k]  = vR[k-1];
    end
    t = '0;
    for (int k = 0; k < STAGES; k++) begin
      t = {1'b0, inA[k][k*CW +: CW]} + {1'b0, inB[k][k*CW +: CW]} + (CW+1)'(inC[k]);
      nS[k] = inS[k];
      nS[k][k*CW +: CW] = t[CW-1:0];
      nC[k] = t[CW];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vR[k]  <= 1'b0;
        cR[k]  <= 1'b0;
        opR[k] <= '0;
        aR[k]  <= '0;
        bR[k]  <= '0;
        sR[k]  <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        vR[k]  <= inV[k];
        cR[k]  <= nC[k];
        opR[k] <= inOp[k];
        aR[k]  <= inA[k];
        bR[k]  <= inB[k];
        sR[k]  <= nS[k];
      end
    end
  end
  assign sgnN          = sR[L][WIDTH-1];
  assign sgnV          = (aR[L][WIDTH-1] == bR[L][WIDTH-1]) && (sgnN != aR[L][WIDTH-1]);
  assign bus.in_ready  = adv;
  assign bus.out_valid = vR[L];
  assign bus.carry     = cR[L];
  assign bus.overflow  = sgnV;
  assign bus.result    = opR[L][1] ? {{(WIDTH-1){1'b0}}, opR[L][0] ? ~cR[L] : sgnN ^ sgnV} : sR[L];
  assign bus.zero      = bus.out_valid && bus.result == '0;
endmodule

// File: doc/mod_add_pipe.md
# mod_add_pipe

Parametrised, pipelined add/subtract/set-less-than unit that replaces the combinational 32-bit add/sub/slt path in the ALU. The operand width is split into `STAGES` equal chunks, and the carry ripples one chunk per clock. This gives one operation per cycle at a fixed latency of `STAGES` cycles. Compared with the previous unit it adds a valid/ready handshake with backpressure, signed overflow and zero flags, a correct signed SLT (N xor V, not just the sign bit), and unsigned SLTU.

## Interface
- `WIDTH`, 32, operand and result width; must be ≥ 2.
- `STAGES`, 4, pipeline depth; must be ≥ 1 and divide `WIDTH` exactly. Chunk width is `CW = WIDTH/STAGES`.
- `clk`  in  1  single clock; all state is updated on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands and op are presented.
- `in_ready`  out  1  unit accepts this cycle.
- `op`  in  2  operation: 00 ADD, 01 SUB, 10 SLT (signed), 11 SLTU.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `out_valid`  out  1  result is valid.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  WIDTH  sum, difference, or zero-extended compare bit.
- `carry`  out  1  carry out of the MSB of the adder.
- `overflow`  out  1  signed overflow of the adder operation.
- `zero`  out  1  `result == 0`.

## Operation
- Adder operand: `bsel = b` for ADD; `bsel = ~b` for SUB, SLT and SLTU. Carry-in is 0 for ADD and 1 for the other three ops.
- Subtraction is computed as `a + ~b + 1`. For SUB, `carry = 1` means no borrow, including the case `b = 0`.
- Stage k (0..STAGES-1) adds chunk k, bits `[k*CW +: CW]`, of `a` and `bsel` plus the registered carry from stage k-1. It registers the sum chunk and its carry out.
- Unconsumed operand chunks, `op`, and the valid bit travel forward with the data.
- Final flags and result:
  - `sum` is the full adder output.
  - `N = sum[WIDTH-1]`.
  - `V = (a[MSB] == bsel[MSB]) && (sum[MSB] != a[MSB])`.
  - `result` = `sum` for ADD and SUB; `{0…, N^V}` for SLT; `{0…, ~carry}` for SLTU.
  - `carry` and `overflow` always report the adder operation (the subtraction for SLT and SLTU).
  - `zero` is computed on `result`.
- Flag values are don't-care while `out_valid = 0`.
- With `STAGES = 1` the unit is a single registered full-width add.

## Timing
- Reset (`rst_n` low) acts asynchronously:
  - All stage valid bits clear immediately.
  - All data and carry registers clear to 0.
  - Output values during reset: `out_valid = 0`, `result = 0`, `carry = 0`, `overflow = 0`, `zero = 0`.
  - `in_ready = 1` as soon as `out_valid` is 0.
- Reset mid-operation discards every in-flight op. No result for those ops appears after `rst_n` rises.
- Advance condition: `adv = out_ready || !out_valid`. `in_ready = adv`, purely combinational from `out_ready` and the registered `out_valid`.
- When `adv = 1`, every stage shifts by one. Stage 0 captures the input and its valid bit is `in_valid`.
- When `adv = 0`, all stages hold. `out_valid`, `result` and the flags stay stable until accepted.
- An accept happens when `in_valid && in_ready`. A transfer happens when `out_valid && out_ready`.
- Latency is exactly `STAGES` cycles from accept to `out_valid`, absent stalls. Throughput is one op per cycle.
- Bubbles are not collapsed: a hole in the input stream stays a hole at the output.
- Ops leave in acceptance order, each exactly once. None is lost or duplicated under any `out_ready` pattern.
- A transfer and an accept in the same cycle are both legal and required to sustain full throughput.

## Test plan
All scenarios use `WIDTH = 32`, `STAGES = 4`, with `out_ready = 1` unless stated.
- ADD `0x7FFFFFFF + 0x00000001` accepted at cycle t -> `out_valid` at t+4 with `result = 0x80000000`, `carry = 0`, `overflow = 1`, `zero = 0`.
- ADD `0xFFFFFFFF + 0x00000001` (carry through all 4 chunks) -> `result = 0`, `carry = 1`, `overflow = 0`, `zero = 1`. Then SUB `5 - 5` -> `0`, `carry = 1`, `zero = 1`. Then SUB `0 - 1` -> `0xFFFFFFFF`, `carry = 0`, `overflow = 0`.
- Compare operations:
  - SLT `a = 0x80000000`, `b = 1` -> `result = 1`.
  - SLTU with the same operands -> `result = 0`.
  - SLT `a = 0x7FFFFFFF`, `b = 0xFFFFFFFF` -> `result = 0` and `overflow = 1`.
  - SLTU `a = 3`, `b = 0` -> `result = 0`, `carry = 1`.
- Backpressure: stream 6 back-to-back ADDs `i + 0x100` (i = 0..5). Drop `out_ready` for 3 cycles after the first `out_valid` -> `in_ready = 0` during those 3 cycles, output stable while stalled, results `0x100`..`0x105` delivered in order with no loss or duplicates.
- Bubble: accept ops on cycles t and t+2 only -> `out_valid` at t+4 and t+6 only.
- Reset mid-stream with 3 ops in flight -> `out_valid` drops the same cycle `rst_n` falls, with no clock edge needed. After release, `in_ready = 1`, no stale result appears, and a new ADD `2 + 3` returns `5` after 4 cycles.
